// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encodings,
// default widths, sequential PC increment and timeout counter width.
package fetch_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_PC_INCR = 2;
  localparam int TMO_W       = 8;

  // Legacy-compatible state constants; FAULT is reachable only with FETCH_TIMEOUT_EN
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts consecutive FETCH cycles without ack; expired is high in the
// cycle whose edge would bring the count to LIMIT.
module fetch_timeout_ctr
  import fetch_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMO_W-1:0] count;

  always_ff @(posedge CLK) begin
    if (Reset || clear)
      count <= '0;
    else if (enable)
      count <= count + TMO_W'(1);
  end

  assign expired = enable && (count == TMO_W'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: req/ack read of instruction memory, instruction register with
// valid/ready handoff, and PC update generation. Optional: FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int PC_INCR        = DEF_PC_INCR,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_write,
  output logic [ADDR_W-1:0] pc_next,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              fetch_fault
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic              timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  logic fault_q;

  fetch_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .CLK     (CLK),
    .Reset   (Reset),
    .clear   (state != ST_FETCH),
    .enable  (state == ST_FETCH && !imem_ack && !redirect),
    .expired (timeout_hit)
  );

  assign fetch_fault = fault_q;
`else
  logic [TMO_W-1:0] timeout_unused;
  assign timeout_unused = TMO_W'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
  assign fetch_fault    = 1'b0;
`endif

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = fetch_pc;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= ST_IDLE;
      fetch_pc <= '0;
      ir_out   <= '0;
      ir_valid <= 1'b0;
      ir_pc    <= '0;
      pc_write <= 1'b0;
      pc_next  <= '0;
`ifdef FETCH_TIMEOUT_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      pc_write <= 1'b0;
      // A redirect squashes the held instruction; an outstanding read must still be drained
      if (redirect && state != ST_FAULT) begin
        pc_write <= 1'b1;
        pc_next  <= redirect_pc;
        ir_valid <= 1'b0;
        if ((state == ST_FETCH || state == ST_DRAIN) && !imem_ack)
          state <= ST_DRAIN;
        else
          state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!stall) begin
              fetch_pc <= pc_in;
              state    <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (imem_ack) begin
              ir_out   <= imem_rdata;
              ir_pc    <= fetch_pc;
              ir_valid <= 1'b1;
              pc_write <= 1'b1;
              pc_next  <= fetch_pc + ADDR_W'(PC_INCR);
              state    <= ST_HOLD;
            end else if (timeout_hit) begin
`ifdef FETCH_TIMEOUT_EN
              fault_q <= 1'b1;
`endif
              state   <= ST_FAULT;
            end
          end
          ST_HOLD: begin
            if (ir_ready) begin
              ir_valid <= 1'b0;
              if (!stall) begin
                fetch_pc <= pc_in;
                state    <= ST_FETCH;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_DRAIN: begin
            if (imem_ack)
              state <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; the timeout section
// runs only when FETCH_TIMEOUT_EN is defined.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] pc_in;
  logic        pc_write;
  logic [15:0] pc_next;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_pc;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.TIMEOUT_CYCLES(4)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .pc_in       (pc_in),
    .pc_write    (pc_write),
    .pc_next     (pc_next),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ir_out      (ir_out),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir_pc       (ir_pc),
    .fetch_fault (fetch_fault)
  );

  always #5 CLK = ~CLK;

  // Hold the current inputs across n rising edges, then settle past the edge
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    Reset = 1'b1; pc_in = '0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; ir_ready = 1'b0;
    applyStimulus(2);
    checkOutput("rst_req",   32'(imem_req),    32'h0);
    checkOutput("rst_addr",  32'(imem_addr),   32'h0);
    checkOutput("rst_valid", 32'(ir_valid),    32'h0);
    checkOutput("rst_ir",    32'(ir_out),      32'h0);
    checkOutput("rst_pcw",   32'(pc_write),    32'h0);
    checkOutput("rst_pcn",   32'(pc_next),     32'h0);
    checkOutput("rst_fault", 32'(fetch_fault), 32'h0);

    // Fetch at 0x0010 with two wait cycles
    Reset = 1'b0; pc_in = 16'h0010;
    applyStimulus(1);
    checkOutput("f1_req",  32'(imem_req),  32'h1);
    checkOutput("f1_addr", 32'(imem_addr), 32'h0010);
    applyStimulus(1);
    checkOutput("f2_addr", 32'(imem_addr), 32'h0010);
    imem_ack = 1'b1; imem_rdata = 16'hA123;
    checkOutput("f3_req",  32'(imem_req),  32'h1);
    checkOutput("f3_addr", 32'(imem_addr), 32'h0010);
    applyStimulus(1);
    imem_ack = 1'b0; imem_rdata = '0;
    checkOutput("ack_ir",    32'(ir_out),   32'hA123);
    checkOutput("ack_irpc",  32'(ir_pc),    32'h0010);
    checkOutput("ack_valid", 32'(ir_valid), 32'h1);
    checkOutput("ack_pcw",   32'(pc_write), 32'h1);
    checkOutput("ack_pcn",   32'(pc_next),  32'h0012);
    checkOutput("ack_req",   32'(imem_req), 32'h0);

    // Consumer not ready for five cycles
    pc_in = 16'h0012;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1);
      checkOutput("hold_ir",    32'(ir_out),   32'hA123);
      checkOutput("hold_valid", 32'(ir_valid), 32'h1);
      checkOutput("hold_req",   32'(imem_req), 32'h0);
      checkOutput("hold_pcw",   32'(pc_write), 32'h0);
    end
    ir_ready = 1'b1;
    applyStimulus(1);
    ir_ready = 1'b0;
    checkOutput("next_req",   32'(imem_req),  32'h1);
    checkOutput("next_addr",  32'(imem_addr), 32'h0012);
    checkOutput("next_valid", 32'(ir_valid),  32'h0);

    // Redirect while waiting, late ack drained
    redirect = 1'b1; redirect_pc = 16'h0200;
    applyStimulus(1);
    redirect = 1'b0; pc_in = 16'h0200;
    checkOutput("rd_pcw", 32'(pc_write), 32'h1);
    checkOutput("rd_pcn", 32'(pc_next),  32'h0200);
    checkOutput("rd_req", 32'(imem_req), 32'h0);
    applyStimulus(1);
    checkOutput("drain_pcw", 32'(pc_write), 32'h0);
    checkOutput("drain_req", 32'(imem_req), 32'h0);
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    applyStimulus(1);
    imem_ack = 1'b0;
    checkOutput("drain_valid", 32'(ir_valid), 32'h0);
    checkOutput("drain_ir",    32'(ir_out),   32'hA123);
    checkOutput("drain_idle",  32'(imem_req), 32'h0);
    applyStimulus(1);
    checkOutput("rd_fetch_req",  32'(imem_req),  32'h1);
    checkOutput("rd_fetch_addr", 32'(imem_addr), 32'h0200);

    // Complete 0x0200, then fetch 0xFFFE and check the wrap
    imem_ack = 1'b1; imem_rdata = 16'h1111;
    applyStimulus(1);
    imem_ack = 1'b0;
    checkOutput("f200_pcn", 32'(pc_next), 32'h0202);
    pc_in = 16'hFFFE; ir_ready = 1'b1;
    applyStimulus(1);
    ir_ready = 1'b0;
    checkOutput("wrap_addr", 32'(imem_addr), 32'hFFFE);
    imem_ack = 1'b1; imem_rdata = 16'h2222;
    applyStimulus(1);
    imem_ack = 1'b0;
    checkOutput("wrap_pcn",  32'(pc_next),  32'h0000);
    checkOutput("wrap_pcw",  32'(pc_write), 32'h1);
    checkOutput("wrap_irpc", 32'(ir_pc),    32'hFFFE);
    checkOutput("wrap_ir",   32'(ir_out),   32'h2222);

    // Redirect and ack on the same edge: data is dropped
    pc_in = 16'h0000; ir_ready = 1'b1;
    applyStimulus(1);
    ir_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'h3333; redirect = 1'b1; redirect_pc = 16'h0400;
    applyStimulus(1);
    imem_ack = 1'b0; redirect = 1'b0; pc_in = 16'h0400;
    checkOutput("ra_pcn",   32'(pc_next),  32'h0400);
    checkOutput("ra_pcw",   32'(pc_write), 32'h1);
    checkOutput("ra_valid", 32'(ir_valid), 32'h0);
    checkOutput("ra_ir",    32'(ir_out),   32'h2222);
    checkOutput("ra_req",   32'(imem_req), 32'h0);
    applyStimulus(1);
    checkOutput("ra_next_addr", 32'(imem_addr), 32'h0400);
    checkOutput("ra_next_req",  32'(imem_req),  32'h1);

    // Stall while consuming in HOLD
    imem_ack = 1'b1; imem_rdata = 16'h4444;
    applyStimulus(1);
    imem_ack = 1'b0; pc_in = 16'h0402; stall = 1'b1;
    applyStimulus(1);
    checkOutput("stall_hold_valid", 32'(ir_valid), 32'h1);
    ir_ready = 1'b1;
    applyStimulus(1);
    ir_ready = 1'b0;
    checkOutput("stall_valid", 32'(ir_valid), 32'h0);
    checkOutput("stall_req",   32'(imem_req), 32'h0);
    applyStimulus(2);
    checkOutput("stall_req2", 32'(imem_req), 32'h0);
    stall = 1'b0;
    applyStimulus(1);
    checkOutput("unstall_req",  32'(imem_req),  32'h1);
    checkOutput("unstall_addr", 32'(imem_addr), 32'h0402);

    // Reset in the middle of a fetch, with an ack on the same edge
    Reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h5555;
    applyStimulus(1);
    checkOutput("mrst_req",   32'(imem_req),    32'h0);
    checkOutput("mrst_addr",  32'(imem_addr),   32'h0);
    checkOutput("mrst_ir",    32'(ir_out),      32'h0);
    checkOutput("mrst_valid", 32'(ir_valid),    32'h0);
    checkOutput("mrst_irpc",  32'(ir_pc),       32'h0);
    checkOutput("mrst_pcw",   32'(pc_write),    32'h0);
    checkOutput("mrst_pcn",   32'(pc_next),     32'h0);
    checkOutput("mrst_fault", 32'(fetch_fault), 32'h0);
    Reset = 1'b0; imem_ack = 1'b0;

`ifdef FETCH_TIMEOUT_EN
    // Ack never arrives: four FETCH cycles then FAULT
    pc_in = 16'h0600;
    applyStimulus(1);
    checkOutput("to_req", 32'(imem_req), 32'h1);
    applyStimulus(3);
    checkOutput("to_pre_fault", 32'(fetch_fault), 32'h0);
    checkOutput("to_pre_req",   32'(imem_req),    32'h1);
    applyStimulus(1);
    checkOutput("to_fault",     32'(fetch_fault), 32'h1);
    checkOutput("to_fault_req", 32'(imem_req),    32'h0);
    redirect = 1'b1; redirect_pc = 16'h0700;
    applyStimulus(1);
    redirect = 1'b0;
    checkOutput("to_rd_pcw",   32'(pc_write),    32'h0);
    checkOutput("to_rd_pcn",   32'(pc_next),     32'h0);
    checkOutput("to_rd_fault", 32'(fetch_fault), 32'h1);
    Reset = 1'b1;
    applyStimulus(1);
    Reset = 1'b0;
    checkOutput("to_rst_fault", 32'(fetch_fault), 32'h0);
`else
    // Without the timeout the fetch waits indefinitely and never faults
    pc_in = 16'h0600;
    applyStimulus(10);
    checkOutput("nto_req",   32'(imem_req),    32'h1);
    checkOutput("nto_fault", 32'(fetch_fault), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage that sits directly downstream of the PC register. It takes the current PC, runs a req/ack read to instruction memory and latches the returned word into the instruction register. It presents that word to decode/control with a valid/ready handshake. It also generates the PC write-enable and next-PC value, either sequential increment or branch/jump redirect, fed back to the PC register.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width
- DATA_W, 16, instruction word width
- PC_INCR, 2, sequential PC increment (byte-addressed, 16-bit instructions)
- TIMEOUT_CYCLES, 255, cycles in FETCH without ack before fault (used only with FETCH_TIMEOUT_EN)

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  reset: synchronous, active-high
- pc_in  in  ADDR_W  current PC from PC register
- pc_write  out  1  PC write-enable to PC register (one-cycle pulse)
- pc_next  out  ADDR_W  value to load into PC register
- stall  in  1  hazard/control stall; blocks starting a new fetch
- redirect  in  1  branch/jump taken this cycle
- redirect_pc  in  ADDR_W  redirect target
- imem_req  out  1  memory read request, held until ack
- imem_addr  out  ADDR_W  read address (latched fetch_pc)
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  DATA_W  read data
- ir_out  out  DATA_W  instruction register
- ir_valid  out  1  ir_out holds an unconsumed instruction
- ir_ready  in  1  consumer accepts ir_out this cycle
- ir_pc  out  ADDR_W  address of the instruction in ir_out
- fetch_fault  out  1  sticky fetch timeout (tied 0 without FETCH_TIMEOUT_EN)

Behaviour:
- All registers update on the rising CLK edge only. Reset has priority over every other input.
- Reset state: state=IDLE; all outputs 0 (imem_req, imem_addr, ir_out, ir_valid, ir_pc, pc_write, pc_next, fetch_fault).
- States: IDLE, FETCH, HOLD, DRAIN (plus FAULT with the optional feature).
- IDLE:
  - If !stall: latch fetch_pc<=pc_in and go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - imem_req=1 and imem_addr=fetch_pc, both stable until ack.
  - On imem_ack: ir_out<=imem_rdata, ir_pc<=fetch_pc, ir_valid<=1.
  - Same edge: pc_write<=1 and pc_next<=fetch_pc+PC_INCR, mod 2^ADDR_W, so 0xFFFE+2 wraps to 0x0000.
  - Then go to HOLD; imem_req drops the cycle after ack.
  - Fetch latency: 1 cycle from request to ack minimum; any number of wait cycles is allowed.
- HOLD:
  - pc_write is high only in the first HOLD cycle and low afterwards.
  - ir_valid stays high with ir_out stable until ir_ready=1.
  - On ir_ready: ir_valid<=0.
  - Same edge: if !stall, latch fetch_pc<=pc_in and go to FETCH; else go to IDLE.
  - HOLD lasts at least one cycle, so pc_in already reflects the pc_write issued on entry.
- Redirect (priority over ack-driven pc_write, in any non-reset state):
  - Same edge: pc_write<=1, pc_next<=redirect_pc, ir_valid<=0 (the held instruction is discarded).
  - If in FETCH with no ack this cycle: go to DRAIN.
  - Otherwise, including FETCH with ack in the same cycle: discard the data and go to IDLE. The one-cycle bubble lets the PC register load the target.
- DRAIN:
  - imem_req=0; wait for imem_ack, discard its data, then go to IDLE.
  - A redirect during DRAIN updates pc_next/pc_write and stays in DRAIN.
- Stall: only blocks IDLE->FETCH and HOLD->FETCH. It never aborts an outstanding request and never drops ir_valid.
- Simultaneous ir_ready and redirect in HOLD: the redirect wins; the instruction counts as consumed and the new fetch uses redirect_pc.
- Reset mid-fetch: imem_req drops on the next edge and the in-flight ack is ignored. Memory must tolerate an abandoned request.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on FETCH entry and increments each FETCH cycle without ack.
  - When it reaches TIMEOUT_CYCLES: imem_req<=0, fetch_fault<=1, go to FAULT.
  - FAULT is left only by Reset. Redirect is ignored in FAULT.
- Undefined: no counter and no FAULT state; fetch_fault is tied to 0; FETCH waits for ack indefinitely.

Decomposition:
- Shared package fetch_pkg: state encoding enum (IDLE, FETCH, HOLD, DRAIN, FAULT), PC_INCR, ADDR_W/DATA_W defaults, TIMEOUT counter width.
- One natural sub-module: fetch_timeout_ctr (clear/enable/expired), instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset, then pc_in=0x0010, memory with 2 wait cycles returns 0xA123 -> imem_addr=0x0010 held 3 cycles; then ir_out=0xA123, ir_pc=0x0010, ir_valid=1, one-cycle pc_write with pc_next=0x0012.
- ir_ready held low 5 cycles -> ir_out and ir_valid stable, no new imem_req; ir_ready=1 -> next request at 0x0012 on the following cycle.
- redirect=1, redirect_pc=0x0200 while FETCH is waiting -> pc_write with pc_next=0x0200; DRAIN discards the late ack data 0xBEEF (ir_valid stays 0); next imem_addr=0x0200.
- pc_in=0xFFFE fetch -> pc_next=0x0000; redirect and ack in the same cycle -> pc_next=redirect_pc, data discarded.
- stall=1 in HOLD when ir_ready=1 -> ir_valid falls, no request until stall=0; Reset asserted mid-FETCH -> imem_req=0 and all outputs 0 next cycle.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never arrives -> fetch_fault=1 after 4 FETCH cycles, imem_req=0, redirect ignored until Reset.
